// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the runtime-configurable serial pattern detector.
package seq_det_pkg;

    // Width needed to hold a length or progress value in the range 0..max_len.
    function automatic int calc_len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Power-up pattern (LSB-aligned; bit DEF_LEN_C-1 is the first bit received).
    localparam logic [63:0] DEF_PATTERN_C = 64'b101011;
    localparam int          DEF_LEN_C     = 6;

    // Match-window behaviour after a hit.
    typedef enum logic {
        NON_OVERLAP = 1'b0,
        OVERLAP     = 1'b1
    } overlap_mode_e;

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter; a clear always wins over a simultaneous increment.
module seq_match_counter
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear first, otherwise increment unless already at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with a run-time loadable pattern of 1..MAX_LEN bits,
// overlap / non-overlap matching, input-valid qualification and a saturating hit count.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN     = 16,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = DEF_PATTERN_C[MAX_LEN-1:0],
    parameter int                 DEF_LEN     = DEF_LEN_C,
    localparam int                LEN_W       = calc_len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               data_in,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clear,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic [LEN_W-1:0]   progress,
    output logic               cfg_err
);

    // Active configuration.
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    overlap_mode_e      overlap_q, overlap_d;
    logic               cfg_err_q, cfg_err_d;

    // Detection state. The oldest history bit is never compared after a shift,
    // so only MAX_LEN-1 bits are kept; the incoming bit completes the window.
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LEN_W-1:0]   progress_q, progress_d;
    logic               match_q, match_d;

    // Comparator signals.
    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] cmp_mask;
    logic [LEN_W-1:0]   prog_inc;
    logic               hit;

    // Configuration latch: a load replaces everything and re-evaluates legality.
    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        cfg_err_d = cfg_err_q;
        if (cfg_load) begin
            pattern_d = cfg_pattern;
            len_d     = cfg_len;
            overlap_d = overlap_mode_e'(cfg_overlap);
            cfg_err_d = (cfg_len == '0) || (int'(cfg_len) > MAX_LEN);
        end
    end

    // Masked comparison of the window including the bit arriving this edge.
    always_comb begin
        window   = {hist_q, data_in};
        cmp_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            cmp_mask[i] = (i < int'(len_q));
        end
        prog_inc = (progress_q >= len_q) ? len_q : progress_q + LEN_W'(1);
        hit      = in_valid && !cfg_load && !cfg_err_q && (prog_inc == len_q) &&
                   (((window ^ pattern_q) & cmp_mask) == '0);
    end

    // History and progress update; a load or an illegal config empties the window.
    always_comb begin
        hist_d     = hist_q;
        progress_d = progress_q;
        match_d    = hit;
        if (cfg_load) begin
            hist_d     = '0;
            progress_d = '0;
        end else if (cfg_err_q) begin
            progress_d = '0;
        end else if (in_valid) begin
            hist_d = window[MAX_LEN-2:0];
            if (hit) begin
                progress_d = (overlap_q == OVERLAP) ? len_q : '0;
            end else begin
                progress_d = prog_inc;
            end
        end
    end

    // Configuration and detection registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern_q  <= DEF_PATTERN;
            len_q      <= LEN_W'(DEF_LEN);
            overlap_q  <= OVERLAP;
            cfg_err_q  <= 1'b0;
            hist_q     <= '0;
            progress_q <= '0;
            match_q    <= 1'b0;
        end else begin
            pattern_q  <= pattern_d;
            len_q      <= len_d;
            overlap_q  <= overlap_d;
            cfg_err_q  <= cfg_err_d;
            hist_q     <= hist_d;
            progress_q <= progress_d;
            match_q    <= match_d;
        end
    end

    seq_match_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (hit),
        .clr     (cnt_clear),
        .count   (match_count)
    );

    assign match    = match_q;
    assign progress = progress_q;
    assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: two instances (8-bit and 2-bit counters) share stimulus
// and are compared each cycle against a queue-based window model.
module tb_seq_detector_param;

    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               data_in, in_valid, cfg_load, cfg_overlap, cnt_clear;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;

    logic               match_a, err_a, match_b, err_b;
    logic [7:0]         count_a;
    logic [1:0]         count_b;
    logic [LEN_W-1:0]   progress_a, progress_b;
    logic [23:0]        got_w;

    always #5 clk = ~clk;

    seq_detector_param #(.MAX_LEN(16), .CNT_W(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .in_valid(in_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clear(cnt_clear), .match(match_a),
        .match_count(count_a), .progress(progress_a), .cfg_err(err_a)
    );

    seq_detector_param #(.MAX_LEN(16), .CNT_W(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .in_valid(in_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clear(cnt_clear), .match(match_b),
        .match_count(count_b), .progress(progress_b), .cfg_err(err_b)
    );

    assign got_w = {match_a, progress_a, count_a, err_a, match_b, progress_b, count_b, err_b};

    // Reference model: the window is the list of bits received since the last restart.
    logic [MAX_LEN-1:0] m_pat;
    int                 m_len;
    bit                 m_ovl;
    bit                 m_err;
    bit                 m_q[$];
    bit                 m_match;
    int                 m_cnt_a, m_cnt_b;

    int vec  = 0;
    int miss = 0;

    task automatic model_reset();
        m_pat   = 16'b101011;
        m_len   = 6;
        m_ovl   = 1'b1;
        m_err   = 1'b0;
        m_q.delete();
        m_match = 1'b0;
        m_cnt_a = 0;
        m_cnt_b = 0;
    endtask

    task automatic model_edge();
        bit hit = 1'b0;
        if (cfg_load) begin
            m_pat = cfg_pattern;
            m_len = int'(cfg_len);
            m_ovl = cfg_overlap;
            m_err = (m_len == 0) || (m_len > MAX_LEN);
            m_q.delete();
        end else if (in_valid && !m_err) begin
            m_q.push_back(data_in);
            if (m_q.size() > m_len) void'(m_q.pop_front());
            if (m_q.size() == m_len) begin
                hit = 1'b1;
                for (int k = 0; k < m_len; k++)
                    if (m_q[k] != m_pat[m_len-1-k]) hit = 1'b0;
            end
            if (hit && !m_ovl) m_q.delete();
        end
        m_match = hit;
        if (cnt_clear) begin
            m_cnt_a = 0;
            m_cnt_b = 0;
        end else if (hit) begin
            if (m_cnt_a < 255) m_cnt_a++;
            if (m_cnt_b < 3)   m_cnt_b++;
        end
    endtask

    function automatic logic [23:0] exp_vec();
        return {m_match, 5'(m_q.size()), 8'(m_cnt_a), m_err,
                m_match, 5'(m_q.size()), 2'(m_cnt_b), m_err};
    endfunction

    task automatic tick(input bit din, input bit vld, input bit ld, input bit clr);
        data_in   = din;
        in_valid  = vld;
        cfg_load  = ld;
        cnt_clear = clr;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_cfg(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len, input bit ovl);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        data_in = 1'b0; in_valid = 1'b0; cfg_load = 1'b0; cnt_clear = 1'b0;
        set_cfg('0, '0, 1'b0);
        #20;
        model_reset();
        vec++;
        if (got_w !== 24'd0) begin
            miss++;
            $display("FAIL reset_outputs: got %h required %h", got_w, 24'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_default();
        logic [5:0] s = 6'b101011;
        for (int i = 0; i < 6; i++) begin
            tick(s[5-i], 1'b1, 1'b0, 1'b0);
            vec++;
            if (got_w !== exp_vec() || match_a !== (i == 5)) begin
                miss++;
                $display("FAIL default_bit%0d: got %h required %h", i, got_w, exp_vec());
            end
        end
        vec++;
        if (count_a !== 8'd1) begin
            miss++;
            $display("FAIL default_count: got %0d required 1", count_a);
        end
    endtask

    task automatic test_overlap();
        logic [7:0] s = 8'b10101010;
        set_cfg(16'b1010, 5'd4, 1'b1);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick(s[7-i], 1'b1, 1'b0, 1'b0);
            vec++;
            if (got_w !== exp_vec() || match_a !== (i == 3 || i == 5)) begin
                miss++;
                $display("FAIL overlap_bit%0d: got %h required %h", i, got_w, exp_vec());
            end
        end
        set_cfg(16'b1010, 5'd4, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(s[7-i], 1'b1, 1'b0, 1'b0);
            vec++;
            if (got_w !== exp_vec() || match_a !== (i == 3 || i == 7)) begin
                miss++;
                $display("FAIL nonoverlap_bit%0d: got %h required %h", i, got_w, exp_vec());
            end
        end
    endtask

    task automatic test_gaps();
        logic [5:0] s = 6'b101011;
        set_cfg(16'b101011, 5'd6, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick(s[5-i], 1'b1, 1'b0, 1'b0);
            vec++;
            if (got_w !== exp_vec() || match_a !== (i == 5) || progress_a !== 5'(i + 1)) begin
                miss++;
                $display("FAIL gap_bit%0d: got %h required %h prog %0d", i, got_w, exp_vec(), i + 1);
            end
            for (int g = 0; g < 3; g++) begin
                tick(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
                vec++;
                if (got_w !== exp_vec() || match_a !== 1'b0 || progress_a !== 5'(i + 1)) begin
                    miss++;
                    $display("FAIL gap_idle%0d_%0d: got %h required %h", i, g, got_w, exp_vec());
                end
            end
        end
    endtask

    task automatic test_cfg_err();
        logic [5:0] s = 6'b101011;
        set_cfg(16'hFFFF, 5'd0, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        vec++;
        if (err_a !== 1'b1 || got_w !== exp_vec()) begin
            miss++;
            $display("FAIL cfg_err_len0: got err=%b vec %h required err=1 vec %h", err_a, got_w, exp_vec());
        end
        set_cfg(16'hFFFF, 5'd17, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        vec++;
        if (err_b !== 1'b1 || got_w !== exp_vec()) begin
            miss++;
            $display("FAIL cfg_err_len17: got err=%b vec %h required err=1 vec %h", err_b, got_w, exp_vec());
        end
        for (int i = 0; i < 64; i++) begin
            tick(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
            vec++;
            if (got_w !== exp_vec() || match_a !== 1'b0 || progress_a !== 5'd0) begin
                miss++;
                $display("FAIL cfg_err_rand%0d: got %h required %h", i, got_w, exp_vec());
            end
        end
        set_cfg(16'b101011, 5'd6, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        vec++;
        if (err_a !== 1'b0 || got_w !== exp_vec()) begin
            miss++;
            $display("FAIL cfg_err_clear: got err=%b required err=0", err_a);
        end
        for (int i = 0; i < 6; i++) begin
            tick(s[5-i], 1'b1, 1'b0, 1'b0);
            vec++;
            if (got_w !== exp_vec() || match_a !== (i == 5)) begin
                miss++;
                $display("FAIL cfg_err_reload_bit%0d: got %h required %h", i, got_w, exp_vec());
            end
        end
    endtask

    task automatic test_counter_sat();
        set_cfg(16'b1, 5'd1, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b0);
            vec++;
            if (got_w !== exp_vec() || count_b !== 2'((i < 3) ? i + 1 : 3) || match_b !== 1'b1) begin
                miss++;
                $display("FAIL sat_hit%0d: got cnt=%0d vec %h required vec %h", i, count_b, got_w, exp_vec());
            end
        end
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        vec++;
        if (got_w !== exp_vec() || count_b !== 2'd0 || count_a !== 8'd0 || match_b !== 1'b1) begin
            miss++;
            $display("FAIL sat_clear: got cnt=%0d match=%b required cnt=0 match=1", count_b, match_b);
        end
    endtask

    task automatic test_async_reset();
        logic [5:0] s = 6'b101011;
        set_cfg(16'b101011, 5'd6, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick(s[5-i], 1'b1, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        vec++;
        if (got_w !== 24'd0) begin
            miss++;
            $display("FAIL async_reset: got %h required %h", got_w, 24'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        vec++;
        if (got_w !== exp_vec() || match_a !== 1'b0 || progress_a !== 5'd1) begin
            miss++;
            $display("FAIL after_reset_bit6: got %h required %h", got_w, exp_vec());
        end
        for (int i = 0; i < 5; i++) tick(s[5-i], 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        vec++;
        if (got_w !== exp_vec() || match_a !== 1'b0 || progress_a !== 5'd0) begin
            miss++;
            $display("FAIL load_drops_bit: got %h required %h", got_w, exp_vec());
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            int len = (r == 7) ? 16 : $urandom_range(1, 5);
            set_cfg(16'($urandom), 5'(len), 1'($urandom_range(0, 1)));
            tick(1'b0, 1'b1, 1'b1, 1'b0);
            for (int i = 0; i < 200; i++) begin
                tick(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                     1'b0, ($urandom_range(0, 49) == 0));
                vec++;
                if (got_w !== exp_vec()) begin
                    miss++;
                    $display("FAIL random_r%0d_i%0d: got %h required %h", r, i, got_w, exp_vec());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_overlap();
        test_gaps();
        test_cfg_err();
        test_counter_sat();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
